// File: rtl/ras.sv
// Return address stack: circular array of return targets with a TOS pointer
// and a saturating occupancy count. The backend can restore pointer and
// count from a checkpoint; entry contents are never rolled back.
module ras #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        link_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] link_pc,
    input  logic                        ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ras_ret_pc,
    output logic                        ras_ret_valid,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count,
    input  logic                        update_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
    input  logic [RAS_INDEX_WIDTH:0]    update_ras_count
);

    localparam logic [RAS_INDEX_WIDTH:0] FULL = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);

    logic [RAS_TARGET_WIDTH-1:0] entry [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  index;
    logic [RAS_INDEX_WIDTH:0]    count;
    logic [RAS_INDEX_WIDTH-1:0]  index_inc;
    logic [RAS_INDEX_WIDTH-1:0]  index_dec;

    // Pointer neighbours; the power-of-2 depth makes the wrap implicit.
    assign index_inc = index + RAS_INDEX_WIDTH'(1);
    assign index_dec = index - RAS_INDEX_WIDTH'(1);

    // Outputs come straight from registered state.
    assign ras_ret_pc    = entry[index];
    assign ras_ret_valid = (count != '0);
    assign ras_index     = index;
    assign ras_count     = count;

    // Stack state update: restore > replace > push > pop > hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entry[i] <= '0;
            end
            index <= '0;
            count <= '0;
        end else if (update_valid) begin
            index <= update_ras_index;
            count <= update_ras_count;
        end else if (link_valid && ret_valid) begin
            // A call and a return in the same cycle swap the top target.
            entry[index] <= link_pc;
            if (count == '0) begin
                count <= (RAS_INDEX_WIDTH+1)'(1);
            end
        end else if (link_valid) begin
            // When full, the push lands on the oldest entry and count stays.
            entry[index_inc] <= link_pc;
            index            <= index_inc;
            if (count != FULL) begin
                count <= count + (RAS_INDEX_WIDTH+1)'(1);
            end
        end else if (ret_valid) begin
            // Underflow still moves the pointer so a later restore lines up.
            index <= index_dec;
            if (count != '0) begin
                count <= count - (RAS_INDEX_WIDTH+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed vector table, hand-written corner
// sequences, and a randomized run against a behavioural stack model.
module tb_ras;

    localparam int N = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        link_valid = 1'b0;
    logic [30:0] link_pc = '0;
    logic        ret_valid = 1'b0;
    logic [30:0] ras_ret_pc;
    logic        ras_ret_valid;
    logic [2:0]  ras_index;
    logic [3:0]  ras_count;
    logic        update_valid = 1'b0;
    logic [2:0]  update_ras_index = '0;
    logic [3:0]  update_ras_count = '0;

    int total = 0;
    int bad   = 0;

    // Behavioural model: plain circular buffer with integer pointer/count.
    int m_mem [N];
    int m_idx;
    int m_cnt;

    ras dut (
        .CLK             (CLK),
        .RST             (RST),
        .link_valid      (link_valid),
        .link_pc         (link_pc),
        .ret_valid       (ret_valid),
        .ras_ret_pc      (ras_ret_pc),
        .ras_ret_valid   (ras_ret_valid),
        .ras_index       (ras_index),
        .ras_count       (ras_count),
        .update_valid    (update_valid),
        .update_ras_index(update_ras_index),
        .update_ras_count(update_ras_count)
    );

    always #5 CLK = ~CLK;

    // Illegal restore counts must never be driven.
    always @(posedge CLK) begin
        if (update_valid) begin
            assert (update_ras_count <= 4'(N));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (RST) begin
            for (int i = 0; i < N; i++) m_mem[i] = 0;
            m_idx = 0;
            m_cnt = 0;
        end else if (update_valid) begin
            m_idx = int'(update_ras_index);
            m_cnt = int'(update_ras_count);
        end else if (link_valid && ret_valid) begin
            m_mem[m_idx] = int'(link_pc);
            if (m_cnt < 1) m_cnt = 1;
        end else if (link_valid) begin
            m_idx = (m_idx + 1) % N;
            m_mem[m_idx] = int'(link_pc);
            m_cnt = (m_cnt + 1 > N) ? N : m_cnt + 1;
        end else if (ret_valid) begin
            m_idx = (m_idx + N - 1) % N;
            m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        end
    endtask

    // Drive one cycle of requests, advance one edge, then sample.
    task automatic cyc(input logic l, input logic [30:0] pc, input logic r,
                       input logic u, input logic [2:0] ui, input logic [3:0] uc);
        link_valid       = l;
        link_pc          = pc;
        ret_valid        = r;
        update_valid     = u;
        update_ras_index = ui;
        update_ras_count = uc;
        @(posedge CLK);
        model_step();
        #1;
        link_valid   = 1'b0;
        ret_valid    = 1'b0;
        update_valid = 1'b0;
    endtask

    task automatic push(input logic [30:0] pc);
        cyc(1'b1, pc, 1'b0, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic pop();
        cyc(1'b0, 31'd0, 1'b1, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc(1'b0, 31'd0, 1'b0, 1'b0, 3'd0, 4'd0);
        cyc(1'b0, 31'd0, 1'b0, 1'b0, 3'd0, 4'd0);
        RST = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [2:0] ei, input logic [3:0] ec,
                               input logic [30:0] ep, input logic ev);
        check({tag, ".index"}, 32'(ras_index), 32'(ei));
        check({tag, ".count"}, 32'(ras_count), 32'(ec));
        check({tag, ".pc"},    32'(ras_ret_pc), 32'(ep));
        check({tag, ".valid"}, 32'(ras_ret_valid), 32'(ev));
    endtask

    task automatic check_model(input string tag);
        check_state(tag, 3'(m_idx), 4'(m_cnt), 31'(m_mem[m_idx]), (m_cnt != 0));
    endtask

    typedef struct {
        logic        l;
        logic [30:0] pc;
        logic        r;
        logic        u;
        logic [2:0]  ui;
        logic [3:0]  uc;
        logic [2:0]  ei;
        logic [3:0]  ec;
        logic [30:0] ep;
        logic        ev;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Directed sequence from a fresh reset (LIFO, underflow, replace).
        tbl[0] = '{1'b1, 31'h100, 1'b0, 1'b0, 3'd0, 4'd0, 3'd1, 4'd1, 31'h100, 1'b1};
        tbl[1] = '{1'b1, 31'h200, 1'b0, 1'b0, 3'd0, 4'd0, 3'd2, 4'd2, 31'h200, 1'b1};
        tbl[2] = '{1'b1, 31'h300, 1'b0, 1'b0, 3'd0, 4'd0, 3'd3, 4'd3, 31'h300, 1'b1};
        tbl[3] = '{1'b0, 31'h0,   1'b1, 1'b0, 3'd0, 4'd0, 3'd2, 4'd2, 31'h200, 1'b1};
        tbl[4] = '{1'b0, 31'h0,   1'b1, 1'b0, 3'd0, 4'd0, 3'd1, 4'd1, 31'h100, 1'b1};
        tbl[5] = '{1'b0, 31'h0,   1'b1, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 31'h0,   1'b0};
        tbl[6] = '{1'b0, 31'h0,   1'b1, 1'b0, 3'd0, 4'd0, 3'd7, 4'd0, 31'h0,   1'b0};
        tbl[7] = '{1'b1, 31'hA,   1'b1, 1'b0, 3'd0, 4'd0, 3'd7, 4'd1, 31'hA,   1'b1};
        tbl[8] = '{1'b1, 31'hC,   1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 4'd2, 31'hC,   1'b1};
        tbl[9] = '{1'b1, 31'hB,   1'b1, 1'b0, 3'd0, 4'd0, 3'd0, 4'd2, 31'hB,   1'b1};

        // Randomized run first so the later reset must clear dirty entries.
        do_reset();
        check_model("rand_rst");
        for (int i = 0; i < 400; i++) begin
            logic        u;
            logic [30:0] pc;
            u  = ($urandom_range(0, 7) == 0);
            pc = 31'($urandom);
            cyc(1'($urandom), pc, 1'($urandom), u, 3'($urandom_range(0, 7)),
                4'($urandom_range(0, N)));
            check_model("rand");
        end

        // Reset clears pointer, count and every entry.
        do_reset();
        check_state("reset", 3'd0, 4'd0, 31'd0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].l, tbl[i].pc, tbl[i].r, tbl[i].u, tbl[i].ui, tbl[i].uc);
            check_state($sformatf("vec%0d", i), tbl[i].ei, tbl[i].ec, tbl[i].ep, tbl[i].ev);
        end

        // Overflow: nine pushes overwrite the oldest entry.
        do_reset();
        for (int i = 1; i <= 9; i++) push(31'(i));
        check_state("ovf_full", 3'd1, 4'd8, 31'h9, 1'b1);
        for (int i = 9; i >= 2; i--) begin
            check($sformatf("ovf_pop%0d", i), 32'(ras_ret_pc), 32'(i));
            pop();
        end
        check("ovf_end.count", 32'(ras_count), 32'd0);
        check("ovf_end.valid", 32'(ras_ret_valid), 32'd0);

        // Replace on a non-empty stack keeps pointer and count.
        do_reset();
        push(31'hA);
        cyc(1'b1, 31'hB, 1'b1, 1'b0, 3'd0, 4'd0);
        check_state("replace", 3'd1, 4'd1, 31'hB, 1'b1);

        // Restore wins over a simultaneous push; entries are not rolled back.
        do_reset();
        push(31'h10);
        push(31'h20);
        check("ckpt.index", 32'(ras_index), 32'd2);
        check("ckpt.count", 32'(ras_count), 32'd2);
        push(31'h30);
        push(31'h40);
        cyc(1'b1, 31'h55, 1'b0, 1'b1, 3'd2, 4'd2);
        check_state("restore", 3'd2, 4'd2, 31'h20, 1'b1);
        cyc(1'b0, 31'h0, 1'b0, 1'b1, 3'd3, 4'd3);
        check_state("restore_e3", 3'd3, 4'd3, 31'h30, 1'b1);
        // Reset has priority over a restore in the same cycle.
        RST = 1'b1;
        cyc(1'b1, 31'h77, 1'b0, 1'b1, 3'd5, 4'd5);
        RST = 1'b0;
        check_state("rst_prio", 3'd0, 4'd0, 31'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
